// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared constants and FSM state type for the PE output packer
//               (fp32 accumulator -> bf16 conversion and 64-bit packing).
// Contents    : LANES/ACC_W/OUT_W defaults, fp32/bf16 special-value fields,
//               pack_state_e {IDLE, CONV, OUT}.
// Config      : none (the ReLU option PE_PACK_RELU_EN lives in pe_out_packer).
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int LANES_DEF = 4;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    // Mantissa of the canonical quiet NaN emitted for any fp32 NaN input.
    localparam logic [6:0] BF16_QNAN_MANT = 7'h40;
    // All-ones exponent marks infinity / NaN in both fp32 and bf16.
    localparam logic [7:0] FP32_EXP_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } pack_state_e;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_out_packer_fp32_to_bf16.sv
`default_nettype none
// ============================================================================
// Module      : fp32_to_bf16
// Description : Combinational fp32 -> bf16 converter with round-to-nearest-
//               even. NaN becomes a signed quiet NaN, infinity is kept,
//               denormals flush to signed zero. A rounding carry into the
//               exponent naturally produces infinity (no saturation).
//               When relu is set, any negative non-NaN input (including -0
//               and -inf) yields +0; NaN always passes through.
// Ports       : in   [31:0]  fp32 operand
//               relu         ReLU request for this operand
//               out  [15:0]  bf16 result
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_to_bf16
    import pe_pkg::*;
(
    input  logic [31:0] in,
    input  logic        relu,
    output logic [15:0] out
);

    logic        sign;
    logic [7:0]  exp_f;
    logic [22:0] mant_f;
    logic        is_nan;
    logic        round_up;
    logic [15:0] rounded;

    always_comb begin
        sign     = in[31];
        exp_f    = in[30:23];
        mant_f   = in[22:0];
        is_nan   = (exp_f == FP32_EXP_MAX) && (mant_f != 23'd0);
        // Guard bit set and either sticky bits or an odd LSB: round up.
        round_up = in[15] & ((|in[14:0]) | in[16]);
        rounded  = in[31:16] + {15'd0, round_up};

        out = rounded;
        if (is_nan) begin
            out = {sign, FP32_EXP_MAX, BF16_QNAN_MANT};
        end else if (exp_f == FP32_EXP_MAX) begin
            out = {sign, FP32_EXP_MAX, 7'h00};
        end else if (exp_f == 8'd0) begin
            out = {sign, 15'h0000};
        end

        if (relu && sign && !is_nan) begin
            out = 16'h0000;
        end
    end

endmodule : fp32_to_bf16
`default_nettype wire

// File: rtl/pe_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : pe_out_packer
// Description : Captures LANES fp32 accumulators on a valid/ready handshake,
//               converts them one lane per clock to bf16 (RNE) through a
//               single shared converter, and presents the packed word on a
//               valid/ready output. Capture at edge 0, out_valid after edge
//               LANES; minimum LANES+2 cycles per word.
// Config      : `PE_PACK_RELU_EN - when defined, act_en[i] clamps negative
//               non-NaN lane results to +0. When undefined act_en is ignored.
// Ports       : clk        clock, rising edge
//               rst        asynchronous active-low reset
//               acc_in     LANES*ACC_W accumulators, lane i at [ACC_W*i +: ACC_W]
//               act_en     per-lane ReLU request, sampled with acc_in
//               cap_valid  / cap_ready   capture handshake
//               out_data   LANES*OUT_W packed bf16, lane i at [OUT_W*i +: OUT_W]
//               out_valid  / out_ready   output handshake
//               busy       high while converting or holding the output word
// Revision    : 1.0 - initial release
// ============================================================================
module pe_out_packer
    import pe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*ACC_W-1:0] acc_in,
    input  logic [LANES-1:0]       act_en,
    input  logic                   cap_valid,
    output logic                   cap_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int             LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);

    pack_state_e              state_q, state_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [LANES*ACC_W-1:0]   acc_q, acc_d;
    logic [LANES*OUT_W-1:0]   out_data_q, out_data_d;

    logic [ACC_W-1:0]         acc_sel;
    logic                     relu_sel;
    logic [OUT_W-1:0]         conv_out;

`ifdef PE_PACK_RELU_EN
    logic [LANES-1:0]         act_q, act_d;
`else
    // ReLU disabled: the request inputs are intentionally left unconsumed.
    logic                     act_en_unused;
    assign act_en_unused = ^act_en;
`endif

    // ------------------------------------------------------------------
    // Lane select feeding the single shared converter
    // ------------------------------------------------------------------
    always_comb begin
        acc_sel  = acc_q[ACC_W-1:0];
        relu_sel = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                acc_sel = acc_q[i*ACC_W +: ACC_W];
`ifdef PE_PACK_RELU_EN
                relu_sel = act_q[i];
`endif
            end
        end
    end

    fp32_to_bf16 u_conv (
        .in   (acc_sel),
        .relu (relu_sel),
        .out  (conv_out)
    );

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
`ifdef PE_PACK_RELU_EN
        act_d      = act_q;
`endif
        cap_ready  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                cap_ready = 1'b1;
                if (cap_valid) begin
                    acc_d   = acc_in;
`ifdef PE_PACK_RELU_EN
                    act_d   = act_en;
`endif
                    lane_d  = '0;
                    state_d = CONV;
                end
            end

            CONV: begin
                busy = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_q == LW'(i)) begin
                        out_data_d[i*OUT_W +: OUT_W] = conv_out;
                    end
                end
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = OUT;
                end else begin
                    lane_d  = lane_q + LW'(1);
                end
            end

            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef PE_PACK_RELU_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end
`endif

    assign out_data = out_data_q;

endmodule : pe_out_packer
`default_nettype wire

// File: tb/tb_pe_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_out_packer
// Description : Self-checking bench for pe_out_packer: directed vector table,
//               randomized words against a behavioural model, backpressure
//               and mid-operation reset sequences.
// Config      : honours `PE_PACK_RELU_EN for expected ReLU behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_out_packer;

    localparam int LANES = 4;

`ifdef PE_PACK_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] acc_in = '0;
    logic [3:0]   act_en = '0;
    logic         cap_valid = 1'b0;
    logic         cap_ready;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_out_packer dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .act_en    (act_en),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Reference conversion expressed with integer arithmetic on the value.
    function automatic logic [15:0] ref_bf16(input logic [31:0] x, input bit relu);
        logic [7:0]  e;
        logic [22:0] m;
        logic        s;
        int unsigned hi;
        int unsigned lo;
        bit          nan;
        s   = x[31];
        e   = x[30:23];
        m   = x[22:0];
        nan = (e == 8'd255) && (m != 23'd0);
        if (relu && s && !nan) return 16'h0000;
        if (nan)               return {s, 15'h7FC0};
        if (e == 8'd255)       return {s, 15'h7F80};
        if (e == 8'd0)         return {s, 15'h0000};
        hi = 32'(x) >> 16;
        lo = 32'(x) & 32'hFFFF;
        if (lo > 32'h8000 || (lo == 32'h8000 && (hi % 2) == 1)) hi = hi + 1;
        return hi[15:0];
    endfunction

    function automatic logic [63:0] ref_word(input logic [127:0] acc, input logic [3:0] act);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++)
            w[i*16 +: 16] = ref_bf16(acc[i*32 +: 32], act[i] & RELU_ON);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Captures one word, checks latency and data, then completes the handshake.
    task automatic run_word(input logic [127:0] acc, input logic [3:0] act,
                            input logic [63:0] exp, input string nm);
        int n;
        @(negedge clk);
        acc_in    = acc;
        act_en    = act;
        cap_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));   // ignored outside OUT
        chk({nm, " cap_ready idle"}, 64'(cap_ready), 64'd1);
        @(negedge clk);
        cap_valid = 1'b0;
        acc_in    = ~acc;                       // DUT must work from its copy
        act_en    = ~act;
        chk({nm, " busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'd4);
        chk({nm, " data"}, out_data, exp);
        chk({nm, " cap_ready out"}, 64'(cap_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " valid drop"}, 64'(out_valid), 64'd0);
        chk({nm, " cap_ready back"}, 64'(cap_ready), 64'd1);
    endtask

    typedef struct {
        logic [127:0] acc;
        logic [3:0]   act;
        logic [63:0]  exp;
        string        name;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [127:0] racc;
        logic [3:0]   ract;
        logic [63:0]  held;
        int           n;

        vecs[0] = '{{32'h0000_0000, 32'hC000_0000, 32'h4049_0FDB, 32'h3F80_0000},
                    4'b0000, 64'h0000_C000_4049_3F80, "basic"};
        vecs[1] = '{{32'h7F7F_FFFF, 32'h3F80_8001, 32'h3F81_8000, 32'h3F80_8000},
                    4'b0000, 64'h7F80_3F81_3F82_3F80, "rne"};
        vecs[2] = '{{32'h7FC0_0000, 32'h8000_0001, 32'hFF80_0000, 32'hFF80_0001},
                    4'b0000, 64'h7FC0_8000_FF80_FFC0, "specials"};
        vecs[3] = '{{4{32'hC000_0000}}, 4'b0101,
                    RELU_ON ? 64'hC000_0000_C000_0000 : 64'hC000_C000_C000_C000, "relu"};
        vecs[4] = '{{32'h3F80_0000, 32'hFFC0_0001, 32'hFF80_0000, 32'h8000_0000}, 4'b1111,
                    RELU_ON ? 64'h3F80_FFC0_0000_0000 : 64'h3F80_FFC0_FF80_8000, "relu_special"};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset cap_ready", 64'(cap_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++)
            run_word(vecs[i].acc, vecs[i].act, vecs[i].exp, vecs[i].name);

        // Randomized words, with special exponents mixed in
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < LANES; i++) begin
                racc[i*32 +: 32] = $urandom;
                case ($urandom_range(0, 5))
                    0: racc[i*32+23 +: 8] = 8'hFF;
                    1: racc[i*32+23 +: 8] = 8'h00;
                    2: racc[i*32 +: 16]   = 16'h8000;
                    default: ;
                endcase
            end
            ract = 4'($urandom);
            run_word(racc, ract, ref_word(racc, ract), "random");
        end

        // Backpressure: word held 10 cycles, second capture refused
        @(negedge clk);
        acc_in = vecs[0].acc; act_en = '0; cap_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        acc_in = vecs[1].acc;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp reach out", 64'(out_valid), 64'd1);
        held = out_data;
        chk("bp data", held, vecs[0].exp);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp valid held", 64'(out_valid), 64'd1);
            chk("bp data stable", out_data, vecs[0].exp);
            chk("bp cap_ready low", 64'(cap_ready), 64'd0);
        end
        cap_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp valid drop", 64'(out_valid), 64'd0);
        chk("bp cap_ready back", 64'(cap_ready), 64'd1);
        chk("bp busy idle", 64'(busy), 64'd0);

        // Reset after lane 1 has converted
        @(negedge clk);
        acc_in = vecs[1].acc; act_en = '0; cap_valid = 1'b1;
        @(negedge clk);                 // capture edge passed
        cap_valid = 1'b0;
        repeat (2) @(negedge clk);      // lanes 0 and 1 converted
        rst = 1'b0;
        #1;
        chk("mid-reset out_valid", 64'(out_valid), 64'd0);
        chk("mid-reset cap_ready", 64'(cap_ready), 64'd1);
        chk("mid-reset busy", 64'(busy), 64'd0);
        chk("mid-reset out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("mid-reset no word", 64'(n), 64'd0);
        run_word(vecs[2].acc, vecs[2].act, vecs[2].exp, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_pe_out_packer
`default_nettype wire
